// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults for the TX and RX paths
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_PRESCALE_WIDTH = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - combinational even/odd parity over a data word
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    assign par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serialiser with programmable bit period
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy,
    output logic                      done
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tx_q, tx_d;
    logic                      done_q, done_d;

    logic [PRESCALE_WIDTH-1:0] cnt_last;
    logic                      bit_end;
    logic                      par_bit;

    uart_parity_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_bit_o (par_bit)
    );

    // A programmed prescale of 0 behaves as one cycle per bit.
    assign cnt_last = (presc_q == '0) ? '0 : presc_q - PRESCALE_WIDTH'(1);
    assign bit_end  = (cnt_q == cnt_last);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        presc_d   = presc_q;
        tx_d      = 1'b1;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (data_valid) begin
                    data_d    = p_data;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    presc_d   = prescale;
                    state_d   = START;
                end
            end
            START, PARITY, STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + PRESCALE_WIDTH'(1);
                if (bit_end) begin
                    case (state_q)
                        START:   state_d = DATA;
                        PARITY:  state_d = STOP;
                        default: state_d = IDLE;
                    endcase
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + PRESCALE_WIDTH'(1);
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level and done are registered, so derive them from the next state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
        done_d = (state_d == STOP) && (cnt_d == cnt_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd0;
    logic       tx_out;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } obs_t;

    localparam obs_t IDLE_OBS = '{tx: 1'b1, busy: 1'b0, done: 1'b0};

    obs_t exp_q[$];
    obs_t cur = IDLE_OBS;

    uart_tx_frame #(
        .DATA_WIDTH(8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b, input int p, input logic is_stop);
        obs_t o;
        for (int r = 0; r < p; r++) begin
            o.tx   = b;
            o.busy = 1'b1;
            o.done = is_stop && (r == p - 1);
            exp_q.push_back(o);
        end
    endtask

    // Model: on acceptance expand the whole frame into per-cycle expected outputs.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur = IDLE_OBS;
        end else begin
            if (!cur.busy && data_valid) begin
                int p;
                p = (prescale == 0) ? 1 : int'(prescale);
                push_bit(1'b0, p, 1'b0);
                for (int k = 0; k < 8; k++) push_bit(p_data[k], p, 1'b0);
                if (par_en) push_bit(($countones(p_data) % 2 == 1) ^ par_typ, p, 1'b0);
                push_bit(1'b1, p, 1'b1);
            end
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_OBS;
        end
    end

    always @(negedge clk) begin
        chk("tx_out", {31'b0, tx_out}, {31'b0, cur.tx});
        chk("busy", {31'b0, busy}, {31'b0, cur.busy});
        chk("done", {31'b0, done}, {31'b0, cur.done});
    end

    // Issues a request, then scrambles the inputs once the frame has been accepted.
    task automatic send(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt);
        @(negedge clk);
        p_data = d; prescale = ps; par_en = pe; par_typ = pt; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        p_data = ~d; prescale = ps + 6'd3; par_en = ~pe; par_typ = ~pt;
    endtask

    task automatic measure(input int p, output int bcyc, output int dcnt, output int dlast,
                           output logic [0:15] seq);
        int i;
        i = 0; dcnt = 0; dlast = -1; seq = '1;
        while (busy === 1'b1 && i < 2000) begin
            if (i % p == 0 && i / p < 16) seq[i / p] = tx_out;
            if (done === 1'b1) begin
                dcnt++;
                dlast = i;
            end
            i++;
            @(negedge clk);
        end
        bcyc = i;
    endtask

    int          bc, dc, dl, idle_busy;
    logic [0:15] seq;
    logic [10:0] exp11;
    logic [9:0]  exp10;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'b0, tx_out}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        send(8'hA5, 6'd8, 1'b1, 1'b0);
        measure(8, bc, dc, dl, seq);
        exp11 = 11'b01010010101;
        chk("a5_busy_cycles", bc, 32'd88);
        chk("a5_done_count", dc, 32'd1);
        chk("a5_done_cycle", dl, 32'd87);
        chk("a5_line", {21'b0, seq[0:10]}, {21'b0, exp11});

        send(8'h01, 6'd4, 1'b1, 1'b1);
        measure(4, bc, dc, dl, seq);
        chk("x01_odd_cycles", bc, 32'd44);
        chk("x01_odd_parity", {31'b0, seq[9]}, 32'd0);
        send(8'h01, 6'd4, 1'b1, 1'b0);
        measure(4, bc, dc, dl, seq);
        chk("x01_even_cycles", bc, 32'd44);
        chk("x01_even_parity", {31'b0, seq[9]}, 32'd1);

        send(8'hFF, 6'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        chk("ff_busy_last", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("ff_busy_fell", {31'b0, busy}, 32'd0);
        p_data = 8'h81; prescale = 6'd0; par_en = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("b2b_accepted", {31'b0, busy}, 32'd1);
        measure(1, bc, dc, dl, seq);
        exp10 = 10'b0100000011;
        chk("b2b_cycles", bc, 32'd10);
        chk("b2b_line", {22'b0, seq[0:9]}, {22'b0, exp10});

        send(8'hA5, 6'd8, 1'b0, 1'b0);
        fork
            measure(8, bc, dc, dl, seq);
            begin
                repeat (20) @(negedge clk);
                p_data = 8'h3C; data_valid = 1'b1;
                @(negedge clk);
                data_valid = 1'b0;
            end
        join
        exp10 = 10'b0101001011;
        chk("drop_cycles", bc, 32'd80);
        chk("drop_line", {22'b0, seq[0:9]}, {22'b0, exp10});
        idle_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
        end
        chk("drop_no_second", idle_busy, 32'd0);

        send(8'hC3, 6'd16, 1'b1, 1'b0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_tx", {31'b0, tx_out}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);

        send(8'h55, 6'd2, 1'b0, 1'b0);
        measure(2, bc, dc, dl, seq);
        exp10 = 10'b0101010101;
        chk("x55_cycles", bc, 32'd20);
        chk("x55_line", {22'b0, seq[0:9]}, {22'b0, exp10});
        chk("x55_done_count", dc, 32'd1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
